// File: rtl/ucie_ctl_err_pkg.sv
// Shared types and constants for the UCIe controller error logger:
// write-sequencer states, first-error header layout and default CSR addresses.
package ucie_ctl_err_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_STATUS = 2'd1,
        WR_HDR    = 2'd2,
        WR_CNT    = 2'd3
    } wrState_e;

    localparam int PTR_W        = 5;
    localparam int HDR_VLD_BIT  = 31;
    localparam int HDR_PTR_MSB  = 4;
    localparam int HDR_PTR_LSB  = 0;

    localparam logic [7:0] DEF_STATUS_ADDR   = 8'h10;
    localparam logic [7:0] DEF_HDR_ADDR      = 8'h14;
    localparam logic [7:0] DEF_CNT_BASE_ADDR = 8'h20;

endpackage

// File: rtl/ucie_ctl_err_logger_if.sv
// CSR write port between the error logger (master) and the CSR block (slave).
// Valid/ready handshake: a write completes in a cycle where wr and ready are both high.
interface ucie_ctl_err_logger_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;

    modport master (output wr, output addr, output wdata, input ready);
    modport slave  (input wr, input addr, input wdata, output ready);
endinterface

// File: rtl/ucie_ctl_err_prio_enc.sv
// Lowest-set-bit finder: returns the index of the least significant set bit
// of vec_i and whether any bit was set at all.
module ucie_ctl_err_prio_enc
    import ucie_ctl_err_pkg::*;
#(
    parameter int W     = 12,
    parameter int IDX_W = PTR_W
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (vec_i[k]) begin
                idx_o   = IDX_W'(k);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ucie_ctl_err_logger.sv
// UCIe D2D adapter error logger: classifies error events, keeps sticky status and a
// first-error header, and pushes them to CSR. Define UCIE_CTL_ERR_CNT_EN for per-source counters.
module ucie_ctl_err_logger
    import ucie_ctl_err_pkg::*;
#(
    parameter int                  NUM_SRC       = 12,
    parameter int                  ADDR_W        = 8,
    parameter int                  DATA_W        = 32,
    parameter logic [NUM_SRC-1:0]  CORR_MASK     = 12'h003,
    parameter logic [NUM_SRC-1:0]  FATAL_MASK    = 12'hF00,
    parameter logic [ADDR_W-1:0]   STATUS_ADDR   = DEF_STATUS_ADDR,
    parameter logic [ADDR_W-1:0]   HDR_ADDR      = DEF_HDR_ADDR,
    parameter logic [ADDR_W-1:0]   CNT_BASE_ADDR = DEF_CNT_BASE_ADDR,
    parameter int                  CNT_W         = 8
) (
    input  logic                   i_fdi_lclk,
    input  logic                   i_rst,
    input  logic [NUM_SRC-1:0]     i_err_src,
    input  logic [NUM_SRC-1:0]     i_clr_status,
    ucie_ctl_err_logger_if.master  csr,
    output logic                   o_fdi_pl_error,
    output logic                   o_fdi_pl_nferror,
    output logic                   o_fdi_pl_cerror,
    output logic [PTR_W-1:0]       o_first_err_ptr,
    output logic                   o_first_err_vld
);

    localparam logic [NUM_SRC-1:0] NF_MASK = ~(CORR_MASK | FATAL_MASK);

    logic [NUM_SRC-1:0] srcIn_q, srcDly_q, newEvt;
    logic [NUM_SRC-1:0] status_d, status_q;
    logic               dirty_d, dirty_q;
    logic               hdrPend_q, vld_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               fatal_q, nf_q, corr_q;
    logic [PTR_W-1:0]   firstIdx;
    logic               firstFound;
    logic               startStatus, accept, hdrAccept, capture;
    logic [DATA_W-1:0]  hdrWord;

    wrState_e           state_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    assign newEvt      = srcIn_q & ~srcDly_q;
    assign startStatus = (state_q == IDLE) && dirty_q;
    assign accept      = wr_q && csr.ready;
    assign hdrAccept   = accept && (state_q == WR_HDR);
    assign capture     = (status_q == '0) && firstFound;

    ucie_ctl_err_prio_enc #(.W(NUM_SRC), .IDX_W(PTR_W)) u_first_enc (
        .vec_i   (newEvt),
        .idx_o   (firstIdx),
        .found_o (firstFound)
    );

    // Set wins over clear; a status change after the snapshot re-arms dirty.
    always_comb begin
        status_d = (status_q & ~i_clr_status) | newEvt;
        dirty_d  = dirty_q;
        if (startStatus) dirty_d = 1'b0;
        if (status_d != status_q) dirty_d = 1'b1;
    end

    always_comb begin
        hdrWord = '0;
        hdrWord[HDR_VLD_BIT] = 1'b1;
        hdrWord[HDR_PTR_MSB:HDR_PTR_LSB] = ptr_q;
    end

    always_ff @(posedge i_fdi_lclk or posedge i_rst) begin
        if (i_rst) begin
            srcIn_q   <= '0;
            srcDly_q  <= '0;
            status_q  <= '0;
            dirty_q   <= 1'b0;
            hdrPend_q <= 1'b0;
            vld_q     <= 1'b0;
            ptr_q     <= '0;
            fatal_q   <= 1'b0;
            nf_q      <= 1'b0;
            corr_q    <= 1'b0;
        end else begin
            srcIn_q  <= i_err_src;
            srcDly_q <= srcIn_q;
            status_q <= status_d;
            dirty_q  <= dirty_d;
            fatal_q  <= |(status_d & FATAL_MASK);
            nf_q     <= |(newEvt & NF_MASK);
            corr_q   <= |(newEvt & CORR_MASK);
            if (capture) begin
                vld_q <= 1'b1;
                ptr_q <= firstIdx;
            end else if (vld_q && (status_d == '0)) begin
                vld_q <= 1'b0;
            end
            if (capture) hdrPend_q <= 1'b1;
            else if (hdrAccept) hdrPend_q <= 1'b0;
        end
    end

`ifdef UCIE_CTL_ERR_CNT_EN
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [NUM_SRC-1:0] chg_q;
    logic [PTR_W-1:0]   cntIdx, cntIdx_q;
    logic               cntFound;
    logic [CNT_W-1:0]   cntSel;
    logic               cntAccept;

    assign cntAccept = accept && (state_q == WR_CNT);

    ucie_ctl_err_prio_enc #(.W(NUM_SRC), .IDX_W(PTR_W)) u_cnt_enc (
        .vec_i   (chg_q),
        .idx_o   (cntIdx),
        .found_o (cntFound)
    );

    always_comb begin
        cntSel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cntIdx == PTR_W'(k)) cntSel = cnt_q[k];
        end
    end

    // Every event marks its counter for a write, even once saturated.
    always_ff @(posedge i_fdi_lclk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
            chg_q <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (newEvt[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
                if (newEvt[k]) chg_q[k] <= 1'b1;
                else if (cntAccept && (cntIdx_q == PTR_W'(k))) chg_q[k] <= 1'b0;
            end
        end
    end
`endif

    // Write sequencer; every state change passes through a cycle with wr low.
    always_ff @(posedge i_fdi_lclk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef UCIE_CTL_ERR_CNT_EN
            cntIdx_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (dirty_q) begin
                        state_q <= WR_STATUS;
                        wr_q    <= 1'b1;
                        addr_q  <= STATUS_ADDR;
                        wdata_q <= DATA_W'(status_q);
                    end
`ifdef UCIE_CTL_ERR_CNT_EN
                    else if (|chg_q) state_q <= WR_CNT;
`endif
                end
                WR_STATUS: begin
                    if (csr.ready) begin
                        wr_q <= 1'b0;
                        if (hdrPend_q) state_q <= WR_HDR;
`ifdef UCIE_CTL_ERR_CNT_EN
                        else if (|chg_q) state_q <= WR_CNT;
`endif
                        else state_q <= IDLE;
                    end
                end
                WR_HDR: begin
                    if (!wr_q) begin
                        wr_q    <= 1'b1;
                        addr_q  <= HDR_ADDR;
                        wdata_q <= hdrWord;
                    end else if (csr.ready) begin
                        wr_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`ifdef UCIE_CTL_ERR_CNT_EN
                WR_CNT: begin
                    if (!wr_q) begin
                        if (cntFound) begin
                            wr_q     <= 1'b1;
                            addr_q   <= CNT_BASE_ADDR + (ADDR_W'(cntIdx) << 2);
                            wdata_q  <= DATA_W'(cntSel);
                            cntIdx_q <= cntIdx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (csr.ready) begin
                        wr_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign csr.wr           = wr_q;
    assign csr.addr         = addr_q;
    assign csr.wdata        = wdata_q;
    assign o_fdi_pl_error   = fatal_q;
    assign o_fdi_pl_nferror = nf_q;
    assign o_fdi_pl_cerror  = corr_q;
    assign o_first_err_ptr  = ptr_q;
    assign o_first_err_vld  = vld_q;

endmodule

// File: tb/tb_ucie_ctl_err_logger.sv
// Directed testbench for ucie_ctl_err_logger: event classification, status/header
// writes, stall stability, set-vs-clear priority, async reset and (optionally) counters.
module tb_ucie_ctl_err_logger;

`ifdef UCIE_CTL_ERR_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 8;
`endif

    logic        clk;
    logic        rst;
    logic [11:0] errSrc;
    logic [11:0] clrStatus;
    logic        plError, plNfError, plCError;
    logic [4:0]  firstPtr;
    logic        firstVld;

    int checks;
    int errors;
    int acceptCnt;

    ucie_ctl_err_logger_if #(.ADDR_W(8), .DATA_W(32)) csrIf ();

    ucie_ctl_err_logger #(.CNT_W(TB_CNT_W)) dut (
        .i_fdi_lclk       (clk),
        .i_rst            (rst),
        .i_err_src        (errSrc),
        .i_clr_status     (clrStatus),
        .csr              (csrIf),
        .o_fdi_pl_error   (plError),
        .o_fdi_pl_nferror (plNfError),
        .o_fdi_pl_cerror  (plCError),
        .o_first_err_ptr  (firstPtr),
        .o_first_err_vld  (firstVld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts accepted status/header writes only; counter writes are ignored here.
    always @(posedge clk) begin
        if (csrIf.wr && csrIf.ready && (csrIf.addr == 8'h10 || csrIf.addr == 8'h14))
            acceptCnt++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Waits (bounded) for a status or header write to be presented.
    task automatic waitWrite(input int maxCyc, output logic got);
        got = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            if (csrIf.wr === 1'b1 && (csrIf.addr == 8'h10 || csrIf.addr == 8'h14)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clearAll();
        errSrc      = '0;
        csrIf.ready = 1'b1;
        @(negedge clk);
        clrStatus = '1;
        @(negedge clk);
        clrStatus = '0;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; errSrc = '0; clrStatus = '0; csrIf.ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (csrIf.wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b want 0", csrIf.wr); end
        checks++; if (plError !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b want 0", plError); end
        checks++; if ({plNfError, plCError} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 00", {plNfError, plCError}); end
        checks++; if ({firstVld, firstPtr} !== 6'h00) begin errors++; $display("[TB] FAIL reset_first: got %h want 00", {firstVld, firstPtr}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_corr_src0();
        logic got;
        csrIf.ready = 1'b1;
        errSrc[0] = 1'b1;
        @(negedge clk);
        checks++; if (plCError !== 1'b0) begin errors++; $display("[TB] FAIL cerr_early: got %b want 0", plCError); end
        @(negedge clk);
        checks++; if (plCError !== 1'b1) begin errors++; $display("[TB] FAIL cerr_pulse: got %b want 1", plCError); end
        checks++; if ({firstVld, firstPtr} !== {1'b1, 5'd0}) begin errors++; $display("[TB] FAIL cerr_first: got %h want 20", {firstVld, firstPtr}); end
        checks++; if (csrIf.wr !== 1'b0) begin errors++; $display("[TB] FAIL cerr_wr_early: got %b want 0", csrIf.wr); end
        @(negedge clk);
        checks++; if (plCError !== 1'b0) begin errors++; $display("[TB] FAIL cerr_one_cycle: got %b want 0", plCError); end
        checks++; if ({csrIf.wr, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h10, 32'h1}) begin errors++;
            $display("[TB] FAIL cerr_status_wr: got wr=%b addr=%h data=%h want 1/10/00000001", csrIf.wr, csrIf.addr, csrIf.wdata); end
        @(negedge clk);
        waitWrite(8, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h14, 32'h8000_0000}) begin errors++;
            $display("[TB] FAIL cerr_hdr_wr: got %b/%h/%h want 1/14/80000000", got, csrIf.addr, csrIf.wdata); end
        clrStatus[0] = 1'b1;
        @(negedge clk);
        clrStatus = '0;
        checks++; if (firstVld !== 1'b0) begin errors++; $display("[TB] FAIL cerr_vld_clear: got %b want 0", firstVld); end
        waitWrite(8, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h10, 32'h0}) begin errors++;
            $display("[TB] FAIL cerr_clear_wr: got %b/%h/%h want 1/10/00000000", got, csrIf.addr, csrIf.wdata); end
        @(negedge clk);
        errSrc = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_multi_src();
        logic got;
        errSrc = 12'h208;
        repeat (2) @(negedge clk);
        checks++; if ({plNfError, plCError} !== 2'b10) begin errors++; $display("[TB] FAIL multi_pulses: got %b want 10", {plNfError, plCError}); end
        checks++; if (plError !== 1'b1) begin errors++; $display("[TB] FAIL multi_fatal: got %b want 1", plError); end
        checks++; if (firstPtr !== 5'd3) begin errors++; $display("[TB] FAIL multi_ptr: got %0d want 3", firstPtr); end
        @(negedge clk);
        checks++; if (plNfError !== 1'b0) begin errors++; $display("[TB] FAIL multi_nf_one: got %b want 0", plNfError); end
        waitWrite(8, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h10, 32'h208}) begin errors++;
            $display("[TB] FAIL multi_status_wr: got %b/%h/%h want 1/10/00000208", got, csrIf.addr, csrIf.wdata); end
        @(negedge clk);
        waitWrite(8, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h14, 32'h8000_0003}) begin errors++;
            $display("[TB] FAIL multi_hdr_wr: got %b/%h/%h want 1/14/80000003", got, csrIf.addr, csrIf.wdata); end
        @(negedge clk);
        clrStatus[9] = 1'b1;
        @(negedge clk);
        clrStatus = '0;
        checks++; if (plError !== 1'b0) begin errors++; $display("[TB] FAIL multi_fatal_drop: got %b want 0", plError); end
        clearAll();
    endtask

    task automatic test_stall();
        logic        got, stable;
        logic [7:0]  a0;
        logic [31:0] d0;
        int          acc0;
        csrIf.ready = 1'b0;
        errSrc[4] = 1'b1;
        waitWrite(10, got);
        a0 = csrIf.addr; d0 = csrIf.wdata;
        checks++; if ({got, a0, d0} !== {1'b1, 8'h10, 32'h10}) begin errors++;
            $display("[TB] FAIL stall_first: got %b/%h/%h want 1/10/00000010", got, a0, d0); end
        stable = 1'b1;
        acc0 = acceptCnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) errSrc[5] = 1'b1;
            if (csrIf.wr !== 1'b1 || csrIf.addr !== a0 || csrIf.wdata !== d0) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("[TB] FAIL stall_stable: got %b want 1", stable); end
        csrIf.ready = 1'b1;
        @(negedge clk);
        checks++; if (acceptCnt - acc0 !== 1) begin errors++; $display("[TB] FAIL stall_accepts: got %0d want 1", acceptCnt - acc0); end
        waitWrite(8, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h14, 32'h8000_0004}) begin errors++;
            $display("[TB] FAIL stall_hdr_wr: got %b/%h/%h want 1/14/80000004", got, csrIf.addr, csrIf.wdata); end
        @(negedge clk);
        waitWrite(8, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h10, 32'h30}) begin errors++;
            $display("[TB] FAIL stall_rewrite: got %b/%h/%h want 1/10/00000030", got, csrIf.addr, csrIf.wdata); end
        clearAll();
    endtask

    task automatic test_set_clear_same();
        logic got, sawWrite;
        errSrc[2] = 1'b1;
        waitWrite(10, got);
        @(negedge clk);
        waitWrite(10, got);
        @(negedge clk);
        errSrc[2] = 1'b0;
        repeat (3) @(negedge clk);
        errSrc[2] = 1'b1;
        @(negedge clk);
        clrStatus[2] = 1'b1;
        @(negedge clk);
        clrStatus = '0;
        checks++; if ({plNfError, firstVld} !== 2'b11) begin errors++; $display("[TB] FAIL setclr_flags: got %b want 11", {plNfError, firstVld}); end
        sawWrite = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (csrIf.wr && csrIf.addr == 8'h10) sawWrite = 1'b1;
        end
        checks++; if (sawWrite !== 1'b0) begin errors++; $display("[TB] FAIL setclr_nowrite: got %b want 0", sawWrite); end
        errSrc[6] = 1'b1;
        waitWrite(10, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h10, 32'h44}) begin errors++;
            $display("[TB] FAIL setclr_status: got %b/%h/%h want 1/10/00000044", got, csrIf.addr, csrIf.wdata); end
        clearAll();
    endtask

    task automatic test_reset_mid_write();
        logic got, sawWrite;
        csrIf.ready = 1'b0;
        errSrc[7] = 1'b1;
        waitWrite(10, got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL rstw_pending: got %b want 1", got); end
        #1 rst = 1'b1;
        errSrc = '0;
        #1;
        checks++; if ({csrIf.wr, firstVld, firstPtr} !== 7'h00) begin errors++;
            $display("[TB] FAIL rstw_async: got wr=%b vld=%b ptr=%0d want 0/0/0", csrIf.wr, firstVld, firstPtr); end
        @(negedge clk);
        rst = 1'b0;
        csrIf.ready = 1'b1;
        sawWrite = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (csrIf.wr) sawWrite = 1'b1;
        end
        checks++; if (sawWrite !== 1'b0) begin errors++; $display("[TB] FAIL rstw_quiet: got %b want 0", sawWrite); end
        errSrc[8] = 1'b1;
        waitWrite(10, got);
        checks++; if ({got, csrIf.addr, csrIf.wdata} !== {1'b1, 8'h10, 32'h100}) begin errors++;
            $display("[TB] FAIL rstw_new_wr: got %b/%h/%h want 1/10/00000100", got, csrIf.addr, csrIf.wdata); end
        checks++; if (plError !== 1'b1) begin errors++; $display("[TB] FAIL rstw_fatal: got %b want 1", plError); end
        clearAll();
    endtask

`ifdef UCIE_CTL_ERR_CNT_EN
    task automatic test_counter();
        logic [31:0] seen [5];
        int          n;
        n = 0;
        for (int i = 0; i < 5; i++) seen[i] = '0;
        for (int ev = 0; ev < 5; ev++) begin
            errSrc[1] = 1'b1;
            repeat (2) @(negedge clk);
            errSrc[1] = 1'b0;
            repeat (14) begin
                @(negedge clk);
                if (csrIf.wr && csrIf.addr == 8'h24) begin
                    if (n < 5) seen[n] = csrIf.wdata;
                    n++;
                end
            end
        end
        checks++; if (n !== 5) begin errors++; $display("[TB] FAIL cnt_writes: got %0d want 5", n); end
        checks++; if ({seen[0], seen[1], seen[2], seen[3]} !== {32'd1, 32'd2, 32'd3, 32'd3}) begin errors++;
            $display("[TB] FAIL cnt_values: got %0d,%0d,%0d,%0d want 1,2,3,3", seen[0], seen[1], seen[2], seen[3]); end
        checks++; if (seen[4] !== 32'd3) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d want 3", seen[4]); end
        clearAll();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        acceptCnt = 0;
        test_reset();
        test_corr_src0();
        test_multi_src();
        test_stall();
        test_set_clear_same();
        test_reset_mid_write();
`ifdef UCIE_CTL_ERR_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
